// File: rtl/pc_unit.sv
// Program counter: sequential / branch / return-address next-PC select with HALT/RUN control.
// Latency: one cycle from sampled inputs to pc. Backpressure: stall=1 or write_en=0 holds pc.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       STEP         = 2,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  input  logic             resume,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             halted,
  output logic             pc_updated,
  output logic             ras_empty,
  output logic             ras_full
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             halted_q;
  logic             upd_q, upd_d;
  logic             run_go;
  logic             do_pop;
  logic [WIDTH-1:0] ras_top;

  assign pc_seq = pc_q + WIDTH'(STEP);
  // Only an un-halted, un-stalled, enabled RUN cycle may move the PC or touch the stack.
  assign run_go = (state_q == RUN) && !halt && !stall && write_en;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr_q;
  logic [PW:0]      ras_cnt_q, ras_cnt_d;
  logic             ras_empty_q, ras_full_q;
  logic             do_push;

  assign do_pop  = run_go && ret && (ras_cnt_q != '0);
  assign do_push = run_go && !ret && branch_taken && call;
  assign ras_top = ras_q[ras_ptr_q - PW'(1)];

  always_comb begin
    ras_cnt_d = ras_cnt_q;
    if (do_push && (ras_cnt_q != DEPTH_C)) begin
      ras_cnt_d = ras_cnt_q + (PW+1)'(1);
    end else if (do_pop) begin
      ras_cnt_d = ras_cnt_q - (PW+1)'(1);
    end
  end

  // Pointer wraps freely, so a push on a full stack overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
    end else begin
      if (do_push) begin
        ras_ptr_q <= ras_ptr_q + PW'(1);
      end else if (do_pop) begin
        ras_ptr_q <= ras_ptr_q - PW'(1);
      end
      ras_cnt_q   <= ras_cnt_d;
      ras_empty_q <= (ras_cnt_d == '0);
      ras_full_q  <= (ras_cnt_d == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_q[ras_ptr_q] <= pc_seq;
    end
  end

  assign ras_empty = ras_empty_q;
  assign ras_full  = ras_full_q;
`else
  logic unused_ras;
  assign unused_ras = ^{call, ret, 1'(RAS_DEPTH)};
  assign do_pop     = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    pc_d  = pc_q;
    upd_d = 1'b0;
    if (run_go) begin
      upd_d = 1'b1;
      if (do_pop) begin
        pc_d = ras_top;
      end else if (branch_taken) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      pc_q     <= RESET_VECTOR;
      upd_q    <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      upd_q <= upd_d;
      case (state_q)
        RUN: begin
          if (halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (resume && !halt) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign halted     = halted_q;
  assign pc_updated = upd_q;

endmodule
